seg_frame_sched: RTL and testbench

Frame scheduler for the serial 7-segment display path. Two independent requesters each offer a 32-bit hex value (8 digits). The block arbitrates between them round-robin and hands the winning value to the digit-decode / parallel-to-serial shifter. It pulses that shifter's start, tracks its finish handshake with timeouts, and returns a per-requester acknowledge once the frame is fully shifted out.

---
 rtl/seg_frame_sched.sv | 154 +++++++++++++++
 tb/tb_seg_frame_sched.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_frame_sched.sv
// seg_frame_sched: round-robin frame scheduler between two 32-bit hex
// requesters and the digit-decode / parallel-to-serial shifter. Issues a
// start pulse, tracks the shifter's fin handshake under timeouts, and
// returns a per-requester ack once the frame has been shifted out.
module seg_frame_sched #(
    parameter int BUSY_TO    = 8,
    parameter int DONE_TO    = 256,
    parameter int GAP_CYCLES = 4
) (
    input  logic        clk,
    input  logic        CR,
    input  logic        req_a,
    input  logic [31:0] num_a,
    output logic        ack_a,
    input  logic        req_b,
    input  logic [31:0] num_b,
    output logic        ack_b,
    input  logic        p2s_fin,
    output logic        p2s_start,
    output logic [31:0] p2s_num,
    output logic        busy,
    output logic        owner,
    output logic        err
);

    localparam int TO_MAX = (BUSY_TO > DONE_TO) ? BUSY_TO : DONE_TO;
    localparam int TO_W   = $clog2(TO_MAX) + 1;
    localparam int GAP_W  = $clog2(GAP_CYCLES) + 1;

    // Last counter value before a timeout / end of gap; counters never pass it.
    localparam logic [TO_W-1:0]  BUSY_LAST = TO_W'(BUSY_TO - 1);
    localparam logic [TO_W-1:0]  DONE_LAST = TO_W'(DONE_TO - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        ACK,
        GAP
    } state_t;

    state_t            state_q, state_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic              rr_q, rr_d;
    logic              owner_q, owner_d;
    logic              err_q, err_d;
    logic [31:0]       num_q, num_d;
    logic              start_q, start_d;
    logic              ack_a_q, ack_a_d;
    logic              ack_b_q, ack_b_d;
    logic              busy_q, busy_d;
    logic              grant_b;

    // State register and all registered outputs.
    always_ff @(posedge clk or posedge CR) begin
        if (CR) begin
            state_q   <= IDLE;
            to_cnt_q  <= '0;
            gap_cnt_q <= '0;
            rr_q      <= 1'b0;
            owner_q   <= 1'b0;
            err_q     <= 1'b0;
            num_q     <= '0;
            start_q   <= 1'b0;
            ack_a_q   <= 1'b0;
            ack_b_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            to_cnt_q  <= to_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            rr_q      <= rr_d;
            owner_q   <= owner_d;
            err_q     <= err_d;
            num_q     <= num_d;
            start_q   <= start_d;
            ack_a_q   <= ack_a_d;
            ack_b_q   <= ack_b_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state logic: arbitration, handshake tracking, timeout and gap counting.
    always_comb begin
        state_d   = state_q;
        to_cnt_d  = '0;
        gap_cnt_d = '0;
        rr_d      = rr_q;
        owner_d   = owner_q;
        err_d     = err_q;
        num_d     = num_q;
        grant_b   = req_b && (!req_a || rr_q);
        case (state_q)
            IDLE: begin
                if (req_a || req_b) begin
                    owner_d = grant_b;
                    rr_d    = ~grant_b;
                    num_d   = grant_b ? num_b : num_a;
                    state_d = START;
                end
            end
            START: state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                if (!p2s_fin) begin
                    state_d = WAIT_DONE;
                end else if (to_cnt_q == BUSY_LAST) begin
                    err_d   = 1'b1;
                    state_d = GAP;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            WAIT_DONE: begin
                if (p2s_fin) begin
                    state_d = ACK;
                end else if (to_cnt_q == DONE_LAST) begin
                    err_d   = 1'b1;
                    state_d = GAP;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ACK: state_d = GAP;
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the upcoming state so every output leaves a flop.
    always_comb begin
        start_d = (state_d == START);
        ack_a_d = (state_d == ACK) && !owner_d;
        ack_b_d = (state_d == ACK) && owner_d;
        busy_d  = (state_d != IDLE);
    end

    assign p2s_start = start_q;
    assign p2s_num   = num_q;
    assign ack_a     = ack_a_q;
    assign ack_b     = ack_b_q;
    assign busy      = busy_q;
    assign owner     = owner_q;
    assign err       = err_q;

endmodule

// File: tb/tb_seg_frame_sched.sv
// Directed self-checking bench for seg_frame_sched.
module tb_seg_frame_sched;

    localparam int BUSY_TO    = 8;
    localparam int DONE_TO    = 256;
    localparam int GAP_CYCLES = 4;

    logic        clk;
    logic        CR;
    logic        req_a, req_b;
    logic [31:0] num_a, num_b;
    logic        ack_a, ack_b;
    logic        p2s_fin;
    logic        p2s_start;
    logic [31:0] p2s_num;
    logic        busy, owner, err;

    int checks   = 0;
    int failures = 0;
    int acks     = 0;

    seg_frame_sched #(
        .BUSY_TO    (BUSY_TO),
        .DONE_TO    (DONE_TO),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk       (clk),
        .CR        (CR),
        .req_a     (req_a),
        .num_a     (num_a),
        .ack_a     (ack_a),
        .req_b     (req_b),
        .num_b     (num_b),
        .ack_b     (ack_b),
        .p2s_fin   (p2s_fin),
        .p2s_start (p2s_start),
        .p2s_num   (p2s_num),
        .busy      (busy),
        .owner     (owner),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One complete frame starting from an IDLE cycle with a request already set.
    task automatic run_frame(input string tag, input logic [31:0] exp_num,
                             input logic exp_owner, input logic drop);
        tick();
        chk1({tag, "_start"}, p2s_start, 1'b1);
        chk32({tag, "_num"}, p2s_num, exp_num);
        chk1({tag, "_owner"}, owner, exp_owner);
        chk1({tag, "_busy"}, busy, 1'b1);
        if (drop) begin
            req_a = 1'b0;
            req_b = 1'b0;
        end
        tick();
        chk1({tag, "_start_low"}, p2s_start, 1'b0);
        p2s_fin = 1'b0;
        repeat (3) tick();
        p2s_fin = 1'b1;
        tick();
        chk1({tag, "_ack_a"}, ack_a, !exp_owner);
        chk1({tag, "_ack_b"}, ack_b, exp_owner);
        tick();
        chk1({tag, "_ack_gone"}, ack_a | ack_b, 1'b0);
        repeat (GAP_CYCLES - 1) tick();
        chk1({tag, "_gap_busy"}, busy, 1'b1);
        tick();
        chk1({tag, "_idle"}, busy, 1'b0);
        chk32({tag, "_num_hold"}, p2s_num, exp_num);
    endtask

    initial begin
        CR      = 1'b1;
        req_a   = 1'b0;
        req_b   = 1'b0;
        num_a   = '0;
        num_b   = '0;
        p2s_fin = 1'b1;

        // Reset state
        repeat (2) tick();
        chk1("rst_start", p2s_start, 1'b0);
        chk32("rst_num", p2s_num, 32'h0);
        chk1("rst_ack", ack_a | ack_b, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_owner", owner, 1'b0);
        chk1("rst_err", err, 1'b0);
        CR = 1'b0;
        tick();

        // Single request with a long shift phase
        req_a = 1'b1;
        num_a = 32'h1234ABCD;
        tick();
        chk1("t1_start", p2s_start, 1'b1);
        chk32("t1_num", p2s_num, 32'h1234ABCD);
        chk1("t1_busy", busy, 1'b1);
        req_a = 1'b0;
        tick();
        chk1("t1_start_low", p2s_start, 1'b0);
        p2s_fin = 1'b0;
        acks = 0;
        repeat (70) begin
            tick();
            if (ack_a || ack_b) acks++;
        end
        chk_int("t1_no_early_ack", acks, 0);
        chk32("t1_num_hold", p2s_num, 32'h1234ABCD);
        p2s_fin = 1'b1;
        tick();
        chk1("t1_ack_a", ack_a, 1'b1);
        chk1("t1_ack_b", ack_b, 1'b0);
        tick();
        chk1("t1_ack_pulse", ack_a, 1'b0);
        repeat (GAP_CYCLES - 1) tick();
        chk1("t1_gap_busy", busy, 1'b1);
        tick();
        chk1("t1_idle", busy, 1'b0);
        chk1("t1_owner", owner, 1'b0);
        chk1("t1_err", err, 1'b0);

        // Contention: rr starts at A after reset
        CR = 1'b1;
        #1;
        CR = 1'b0;
        req_a = 1'b1;
        req_b = 1'b1;
        num_a = 32'hAAAAAAAA;
        num_b = 32'hBBBBBBBB;
        run_frame("rr1", 32'hAAAAAAAA, 1'b0, 1'b0);
        run_frame("rr2", 32'hBBBBBBBB, 1'b1, 1'b0);
        run_frame("rr3", 32'hAAAAAAAA, 1'b0, 1'b0);
        run_frame("rr4", 32'hBBBBBBBB, 1'b1, 1'b1);

        // Busy timeout: fin never drops
        req_a = 1'b1;
        num_a = 32'h33333333;
        tick();
        chk1("bto_start", p2s_start, 1'b1);
        req_a = 1'b0;
        acks = 0;
        repeat (BUSY_TO) begin
            tick();
            if (ack_a || ack_b) acks++;
        end
        chk1("bto_err_pre", err, 1'b0);
        tick();
        if (ack_a || ack_b) acks++;
        chk1("bto_err", err, 1'b1);
        chk1("bto_busy", busy, 1'b1);
        repeat (GAP_CYCLES) begin
            tick();
            if (ack_a || ack_b) acks++;
        end
        chk_int("bto_no_ack", acks, 0);
        chk1("bto_idle", busy, 1'b0);
        req_b = 1'b1;
        num_b = 32'h0BADF00D;
        run_frame("sticky", 32'h0BADF00D, 1'b1, 1'b1);
        chk1("sticky_err", err, 1'b1);

        // Done timeout: fin drops and never returns
        CR = 1'b1;
        #1;
        chk1("rst2_err", err, 1'b0);
        CR = 1'b0;
        req_a = 1'b1;
        num_a = 32'h44444444;
        tick();
        req_a = 1'b0;
        tick();
        p2s_fin = 1'b0;
        acks = 0;
        tick();
        repeat (DONE_TO - 1) begin
            tick();
            if (ack_a || ack_b) acks++;
        end
        chk1("dto_err_pre", err, 1'b0);
        tick();
        if (ack_a || ack_b) acks++;
        chk1("dto_err", err, 1'b1);
        p2s_fin = 1'b1;
        repeat (GAP_CYCLES) begin
            tick();
            if (ack_a || ack_b) acks++;
        end
        chk_int("dto_no_ack", acks, 0);
        chk1("dto_idle", busy, 1'b0);

        // Reset in WAIT_DONE with req_b still pending
        req_b = 1'b1;
        num_b = 32'hCAFEF00D;
        tick();
        chk1("mr_owner_pre", owner, 1'b1);
        tick();
        p2s_fin = 1'b0;
        repeat (2) tick();
        #2;
        CR = 1'b1;
        #1;
        chk1("mr_start", p2s_start, 1'b0);
        chk32("mr_num", p2s_num, 32'h0);
        chk1("mr_ack", ack_a | ack_b, 1'b0);
        chk1("mr_busy", busy, 1'b0);
        chk1("mr_owner", owner, 1'b0);
        chk1("mr_err", err, 1'b0);
        CR = 1'b0;
        p2s_fin = 1'b1;
        tick();
        chk1("mr_regrant_start", p2s_start, 1'b1);
        chk32("mr_regrant_num", p2s_num, 32'hCAFEF00D);
        chk1("mr_regrant_owner", owner, 1'b1);
        num_b = 32'h0;
        req_b = 1'b0;
        tick();
        chk32("mr_num_hold", p2s_num, 32'hCAFEF00D);
        CR = 1'b1;
        #1;
        CR = 1'b0;

        // Late request drop, then a held request starting a second frame
        req_a = 1'b1;
        num_a = 32'h5555AAAA;
        run_frame("drop", 32'h5555AAAA, 1'b0, 1'b1);
        tick();
        chk1("drop_no_restart", p2s_start, 1'b0);
        chk1("drop_no_busy", busy, 1'b0);
        req_a = 1'b1;
        num_a = 32'h600DCAFE;
        run_frame("held1", 32'h600DCAFE, 1'b0, 1'b0);
        num_a = 32'h0F0F1234;
        run_frame("held2", 32'h0F0F1234, 1'b0, 1'b1);
        chk1("final_err", err, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
